// File: rtl/datapath_memory_unit_pkg.sv
// Shared definitions for the datapath memory slice.
//   - mem_mode_e  : READ/WRITE selector for the mode controller
//   - shift_dir_e : direction selector for the logical barrel shifter
//   - DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default word and address widths
package datapath_memory_unit_pkg;

  typedef enum logic {
    MODE_WRITE = 1'b0,
    MODE_READ  = 1'b1
  } mem_mode_e;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;

endpackage

// File: rtl/datapath_memory_unit_if.sv
// Bundle of all non-clock signals of the datapath memory slice.
//   master : the datapath client (drives mode, addresses, write data, shifter operands)
//   slave  : the memory unit (drives write enables, read data, shifter result)
interface datapath_memory_unit_if
  import datapath_memory_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  mode;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  we_a;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] shift_amt;
  logic                  shift_dir;
  logic [DATA_WIDTH-1:0] shift_out;

  modport master (
    output mode, addr_a, data_a, addr_b, data_b,
    output shift_in, shift_amt, shift_dir,
    input  we_a, we_b, q_a, q_b, shift_out
  );

  modport slave (
    input  mode, addr_a, data_a, addr_b, data_b,
    input  shift_in, shift_amt, shift_dir,
    output we_a, we_b, q_a, q_b, shift_out
  );

endinterface

// File: rtl/datapath_memory_unit_dp_bram.sv
// dp_bram: true dual-port synchronous RAM, 2^ADDR_WIDTH x DATA_WIDTH.
//   clk                        : write/read clock
//   rst_n                      : async active-low reset of the output registers only
//   we_x, addr_x, data_x, q_x  : per-port write enable, address, write data,
//                                registered read data (x = a, b)
// Behaviour:
//   - write-first on each port: a writing port's q shows its own write data
//   - same-address double write: port B's data lands in the array
//   - opposite-port read of an address being written returns the old word
module dp_bram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Power-up contents are zero; the array is never reset afterwards.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] q_a_d, q_a_q;
  logic [DATA_WIDTH-1:0] q_b_d, q_b_q;

  // Port B is written after port A so it wins an address collision.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
  end

  // The array read happens before the edge, so an opposite-port read
  // naturally sees the pre-write contents.
  always_comb begin
    q_a_d = mem[addr_a];
    q_b_d = mem[addr_b];
    if (we_a) q_a_d = data_a;
    if (we_b) q_b_d = data_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: rtl/datapath_memory_unit_logic_shifter.sv
// logic_shifter: combinational logical barrel shifter.
//   shift_in  : operand
//   shift_amt : unsigned distance; any value >= DATA_WIDTH yields zero
//   shift_dir : 0 = left, 1 = right; vacated bits are zero-filled
//   shift_out : result
module logic_shifter
  import datapath_memory_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] shift_in,
  input  logic [DATA_WIDTH-1:0] shift_amt,
  input  logic                  shift_dir,
  output logic [DATA_WIDTH-1:0] shift_out
);

  localparam logic [DATA_WIDTH-1:0] AMT_LIMIT = DATA_WIDTH[DATA_WIDTH-1:0];

  always_comb begin
    shift_out = '0;
    if (shift_amt < AMT_LIMIT) begin
      if (shift_dir == SHIFT_RIGHT) shift_out = shift_in >> shift_amt;
      else                          shift_out = shift_in << shift_amt;
    end
  end

endmodule

// File: rtl/datapath_memory_unit_mem_mode_ctrl.sv
// mem_mode_ctrl: turns the single READ/WRITE mode bit into per-port write
// enables. Purely combinational.
//   rst_n      : active-low reset; forces both enables low while asserted
//   mode       : 0 = WRITE (both ports write), 1 = READ (both ports read)
//   we_a, we_b : write enables for RAM ports A and B
module mem_mode_ctrl
  import datapath_memory_unit_pkg::*;
(
  input  logic rst_n,
  input  logic mode,
  output logic we_a,
  output logic we_b
);

  always_comb begin
    we_a = 1'b0;
    we_b = 1'b0;
    // Reset gating here is what suppresses RAM writes during reset, since
    // the array itself carries no reset.
    if (rst_n && (mode == MODE_WRITE)) begin
      we_a = 1'b1;
      we_b = 1'b1;
    end
  end

endmodule

// File: rtl/datapath_memory_unit.sv
// datapath_memory_unit: datapath memory slice top level.
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset (clears read registers, blocks writes)
//   bus   : slave side of datapath_memory_unit_if
//           mode/addr_x/data_x  -> dual-port RAM via the mode controller
//           we_x/q_x            <- write enables and registered read data
//           shift_in/amt/dir    -> logical barrel shifter -> shift_out
// Pure structural wrapper around mem_mode_ctrl, dp_bram and logic_shifter.
module datapath_memory_unit
  import datapath_memory_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  datapath_memory_unit_if.slave  bus
);

  mem_mode_ctrl u_mode_ctrl (
    .rst_n (rst_n),
    .mode  (bus.mode),
    .we_a  (bus.we_a),
    .we_b  (bus.we_b)
  );

  dp_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_a   (bus.we_a),
    .addr_a (bus.addr_a),
    .data_a (bus.data_a),
    .q_a    (bus.q_a),
    .we_b   (bus.we_b),
    .addr_b (bus.addr_b),
    .data_b (bus.data_b),
    .q_b    (bus.q_b)
  );

  logic_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .shift_in  (bus.shift_in),
    .shift_amt (bus.shift_amt),
    .shift_dir (bus.shift_dir),
    .shift_out (bus.shift_out)
  );

endmodule

// File: tb/tb_datapath_memory_unit.sv
// Self-checking bench for datapath_memory_unit: table-driven directed
// vectors, a hand-written reset sequence and a randomized phase checked
// against a behavioural memory/shifter model.
module tb_datapath_memory_unit;

  localparam int DW = 16;
  localparam int AW = 10;

  logic clk;
  logic rst_n;

  datapath_memory_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  datapath_memory_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [DW-1:0] ref_mem [1 << AW];
  logic [DW-1:0] exp_qa, exp_qb;

  typedef struct {
    logic          mode;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
  } mem_vec_t;

  typedef struct {
    logic [DW-1:0] sin;
    logic [DW-1:0] amt;
    logic          dir;
    logic [DW-1:0] sout;
  } shf_vec_t;

  mem_vec_t mvec [11];
  shf_vec_t svec [7];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: a WRITE cycle stores A then B (B wins a collision) and each
  // port returns its own data; a READ cycle returns stored contents.
  task automatic model_step(input logic m, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                            input logic [AW-1:0] ab, input logic [DW-1:0] db);
    if (m == 1'b0) begin
      ref_mem[aa] = da;
      ref_mem[ab] = db;
      exp_qa = da;
      exp_qb = db;
    end else begin
      exp_qa = ref_mem[aa];
      exp_qb = ref_mem[ab];
    end
  endtask

  // Shifter model: multiply/divide by two per position, keep low DW bits.
  function automatic logic [DW-1:0] shift_ref(input logic [DW-1:0] v, input logic [DW-1:0] amt,
                                              input logic dir);
    logic [31:0] p;
    p = {16'b0, v};
    if (amt >= 16'd16) return '0;
    for (int i = 0; i < 32'(amt); i++) p = dir ? (p / 32'd2) : (p * 32'd2);
    return p[DW-1:0];
  endfunction

  task automatic drive(input logic m, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db);
    bus.mode   = m;
    bus.addr_a = aa;
    bus.data_a = da;
    bus.addr_b = ab;
    bus.data_b = db;
  endtask

  initial begin
    mvec[0]  = '{1'b0, 10'h000, 16'h000F, 10'h002, 16'h3000, 16'h000F, 16'h3000};
    mvec[1]  = '{1'b0, 10'h001, 16'h00F0, 10'h003, 16'h0C00, 16'h00F0, 16'h0C00};
    mvec[2]  = '{1'b1, 10'h000, 16'h0000, 10'h002, 16'h0000, 16'h000F, 16'h3000};
    mvec[3]  = '{1'b1, 10'h001, 16'h0000, 10'h003, 16'h0000, 16'h00F0, 16'h0C00};
    mvec[4]  = '{1'b0, 10'h000, 16'h0003, 10'h002, 16'h3FFF, 16'h0003, 16'h3FFF};
    mvec[5]  = '{1'b0, 10'h001, 16'h0030, 10'h003, 16'h3FF0, 16'h0030, 16'h3FF0};
    mvec[6]  = '{1'b1, 10'h000, 16'hAAAA, 10'h002, 16'h5555, 16'h0003, 16'h3FFF};
    mvec[7]  = '{1'b1, 10'h001, 16'hAAAA, 10'h003, 16'h5555, 16'h0030, 16'h3FF0};
    mvec[8]  = '{1'b0, 10'h010, 16'h1111, 10'h010, 16'h2222, 16'h1111, 16'h2222};
    mvec[9]  = '{1'b1, 10'h010, 16'h0000, 10'h010, 16'h0000, 16'h2222, 16'h2222};
    mvec[10] = '{1'b1, 10'h3FF, 16'h0000, 10'h200, 16'h0000, 16'h0000, 16'h0000};

    svec[0] = '{16'h0002, 16'd2,      1'b0, 16'h0008};
    svec[1] = '{16'h0002, 16'd1,      1'b1, 16'h0001};
    svec[2] = '{16'h0002, 16'd16,     1'b1, 16'h0000};
    svec[3] = '{16'h8001, 16'd0,      1'b0, 16'h8001};
    svec[4] = '{16'hFFFF, 16'd15,     1'b1, 16'h0001};
    svec[5] = '{16'hFFFF, 16'd15,     1'b0, 16'h8000};
    svec[6] = '{16'hFFFF, 16'hFFFF,   1'b0, 16'h0000};

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    exp_qa = '0;
    exp_qb = '0;

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    bus.shift_in  = '0;
    bus.shift_amt = '0;
    bus.shift_dir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q_a", bus.q_a, 16'h0000);
    check("reset_q_b", bus.q_b, 16'h0000);
    check("reset_we_a", {15'b0, bus.we_a}, 16'h0000);
    check("reset_we_b", {15'b0, bus.we_b}, 16'h0000);
    // Shifter is independent of reset
    bus.shift_in = 16'h00F0; bus.shift_amt = 16'd4; bus.shift_dir = 1'b1;
    #1;
    check("shift_in_reset", bus.shift_out, 16'h000F);
    rst_n = 1'b1;

    // Shifter vectors
    for (int i = 0; i < 7; i++) begin
      bus.shift_in  = svec[i].sin;
      bus.shift_amt = svec[i].amt;
      bus.shift_dir = svec[i].dir;
      #1;
      check($sformatf("shift_vec%0d", i), bus.shift_out, svec[i].sout);
    end

    // Memory vectors, one clock each
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      drive(mvec[i].mode, mvec[i].aa, mvec[i].da, mvec[i].ab, mvec[i].db);
      #1;
      check($sformatf("mem_vec%0d_we_a", i), {15'b0, bus.we_a}, {15'b0, ~mvec[i].mode});
      check($sformatf("mem_vec%0d_we_b", i), {15'b0, bus.we_b}, {15'b0, ~mvec[i].mode});
      @(posedge clk); #1;
      model_step(mvec[i].mode, mvec[i].aa, mvec[i].da, mvec[i].ab, mvec[i].db);
      check($sformatf("mem_vec%0d_q_a", i), bus.q_a, mvec[i].qa);
      check($sformatf("mem_vec%0d_q_b", i), bus.q_b, mvec[i].qb);
    end

    // Reset asserted mid-WRITE: q clears at once, the pending write is dropped
    drive(1'b0, 10'h005, 16'h1234, 10'h006, 16'h5678);
    @(posedge clk); #1;
    model_step(1'b0, 10'h005, 16'h1234, 10'h006, 16'h5678);
    check("pre_reset_q_a", bus.q_a, 16'h1234);
    check("pre_reset_q_b", bus.q_b, 16'h5678);
    drive(1'b0, 10'h005, 16'hDEAD, 10'h006, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_q_a", bus.q_a, 16'h0000);
    check("async_reset_q_b", bus.q_b, 16'h0000);
    check("async_reset_we_a", {15'b0, bus.we_a}, 16'h0000);
    check("async_reset_we_b", {15'b0, bus.we_b}, 16'h0000);
    @(posedge clk); #1;
    check("reset_hold_q_a", bus.q_a, 16'h0000);
    check("reset_hold_q_b", bus.q_b, 16'h0000);
    rst_n = 1'b1;
    drive(1'b1, 10'h005, 16'h0000, 10'h006, 16'h0000);
    @(posedge clk); #1;
    model_step(1'b1, 10'h005, 16'h0000, 10'h006, 16'h0000);
    check("post_reset_q_a", bus.q_a, exp_qa);
    check("post_reset_q_b", bus.q_b, exp_qb);

    // Randomized phase: small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic          m;
      logic [AW-1:0] aa, ab;
      logic [DW-1:0] da, db, sa;
      m  = 1'($urandom_range(0, 1));
      aa = AW'($urandom_range(0, 15));
      ab = AW'($urandom_range(0, 15));
      da = DW'($urandom);
      db = DW'($urandom);
      drive(m, aa, da, ab, db);
      sa = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 17));
      bus.shift_in  = DW'($urandom);
      bus.shift_amt = sa;
      bus.shift_dir = 1'($urandom_range(0, 1));
      #1;
      check("rand_shift", bus.shift_out, shift_ref(bus.shift_in, bus.shift_amt, bus.shift_dir));
      check("rand_we_a", {15'b0, bus.we_a}, {15'b0, ~m});
      check("rand_we_b", {15'b0, bus.we_b}, {15'b0, ~m});
      @(posedge clk); #1;
      model_step(m, aa, da, ab, db);
      check("rand_q_a", bus.q_a, exp_qa);
      check("rand_q_b", bus.q_b, exp_qb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_memory_unit.md
# datapath_memory_unit

Datapath memory slice: a true dual-port synchronous block RAM, a two-mode write-enable controller, and a combinational logical barrel shifter. The mode controller turns a single READ/WRITE mode bit into per-port write enables. The unit provides the processor datapath with data storage and shift operations.

## Interface
Parameters:
- DATA_WIDTH, 16, word width of RAM, shifter operand and shift amount
- ADDR_WIDTH, 10, RAM address width; depth = 2^ADDR_WIDTH (1024 words)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- mode  in  1  0 = WRITE, 1 = READ
- addr_a  in  ADDR_WIDTH  port A address
- data_a  in  DATA_WIDTH  port A write data
- addr_b  in  ADDR_WIDTH  port B address
- data_b  in  DATA_WIDTH  port B write data
- we_a  out  1  port A write enable from the mode controller
- we_b  out  1  port B write enable from the mode controller
- q_a  out  DATA_WIDTH  port A registered read data
- q_b  out  DATA_WIDTH  port B registered read data
- shift_in  in  DATA_WIDTH  shifter operand
- shift_amt  in  DATA_WIDTH  shift distance, unsigned
- shift_dir  in  1  0 = left, 1 = right
- shift_out  out  DATA_WIDTH  shifter result

## Operation
- **Mode controller:** combinational decode, no internal state.
  - WRITE: we_a = we_b = 1.
  - READ: we_a = we_b = 0.
  - While rst_n = 0, we_a = we_b = 0 regardless of mode.
- **RAM:**
  - 1024 × 16 array, zero-initialised at elaboration.
  - Each port operates independently at its own address.
  - Read-only port: q updates to mem[addr].
  - Writing port: stores its data into mem[addr], and q updates to the new data (write-first).
- **Same-address collision:** both ports write the same address in the same cycle.
  - Port B's data is stored.
  - Each port's q shows its own write data.
- **Read during write, opposite port, same address:** the reading port returns the old contents.
- **Shifter:**
  - Logical shift; vacated bits are filled with 0.
  - shift_amt ≥ DATA_WIDTH gives 0.
  - shift_amt = 0 passes shift_in through unchanged.
  - Pure combinational; independent of clk and rst_n.

## Timing
- **Read latency:** one cycle. An address presented before edge N produces valid q at edge N.
- **Write:** data and address are sampled at the rising edge with we = 1. Contents are visible on the same port's q after that edge.
- **Mode:** a change takes effect on we_a/we_b combinationally. It governs the next rising edge.
- **Reset:**
  - Assertion immediately (asynchronously) clears q_a and q_b to 0.
  - While asserted, q_a and q_b are held at 0 and writes are suppressed.
  - Reset does not clear the RAM array.
  - A write in flight at assertion is dropped.
- **Reset release:** first normal operation at the next rising edge after rst_n goes high.
- **Shifter:** zero latency; output settles within the same cycle.

## Structure
- Shared package holds:
  - MODE_WRITE = 1'b0, MODE_READ = 1'b1
  - SHIFT_LEFT = 1'b0, SHIFT_RIGHT = 1'b1
  - default DATA_WIDTH and ADDR_WIDTH
- Sub-modules: dual-port RAM (`dp_bram`), mode decoder (`mem_mode_ctrl`), shifter (`logic_shifter`). The top level only instantiates and wires them.
- The RAM is coded for block-RAM inference: registered outputs, no reset on the array.

## Test plan
- Shifter: shift_in=0x0002, shift_amt=2, shift_dir=0 → shift_out=0x0008. Then shift_amt=1, shift_dir=1 → shift_out=0x0001. Then shift_amt=16 → 0x0000.
- Dual write then read:
  - WRITE cycle 1: A@0x000=0x000F, B@0x002=0x3000.
  - WRITE cycle 2: A@0x001=0x00F0, B@0x003=0x0C00.
  - READ: addr 0x000/0x002 → q_a=0x000F, q_b=0x3000 one cycle later. Then 0x001/0x003 → 0x00F0/0x0C00.
- Write-first overwrite: WRITE A@0x000=0x0003, B@0x002=0x3FFF → after one edge q_a=0x0003, q_b=0x3FFF. Then A@0x001=0x0030, B@0x003=0x3FF0 → q_a=0x0030, q_b=0x3FF0.
- Mode decode: mode=0 → we_a=we_b=1; mode=1 → both 0; READ cycles leave contents unchanged on re-read.
- Collision: WRITE with both ports at 0x010, A=0x1111, B=0x2222 → q_a=0x1111, q_b=0x2222; later READ 0x010 → 0x2222.
- Reset: assert rst_n=0 mid-WRITE between edges → q_a=q_b=0 immediately, we=0, addressed word unchanged. After release, READ returns pre-reset contents.
